// File: rtl/frame_read_scheduler_pkg.sv
// Shared definitions for the DVI-side frame read scheduler: FSM encoding,
// burst width and the default 640x480 frame geometry.
package frame_read_scheduler_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_VSYNC = 2'd1;
    localparam logic [1:0] ST_FETCH      = 2'd2;
    localparam logic [1:0] ST_FRAME_DONE = 2'd3;

    localparam int BURST_WIDTH = 768;

    // 640 px per line at 32 px per 768-bit burst
    localparam int          DEF_BURSTS_PER_LINE = 20;
    localparam int          DEF_LINES           = 480;
    localparam logic [31:0] DEF_ADDR_INC        = 32'd96;
    localparam logic [31:0] DEF_BASE_A          = 32'h0000_0000;
    localparam logic [31:0] DEF_BASE_B          = 32'h0010_0000;
    localparam int          DEF_FIFO_DEPTH      = 8;
    localparam int          DEF_GAP             = 5;

endpackage

// File: rtl/frame_read_scheduler_credit_counter.sv
// Saturating credit counter: reload to DEPTH, +1 on inc, -1 on dec, zero flag.
// Load takes priority over inc/dec; simultaneous inc and dec cancel out.
module credit_counter #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int          W    = $clog2(DEPTH + 1);
    localparam logic [W-1:0] FULL = W'(DEPTH);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = FULL;
        end else if (inc_i && !dec_i) begin
            if (count_q != FULL) count_d = count_q + W'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= FULL;
        else       count_q <= count_d;
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/frame_read_scheduler.sv
// Walks a double-buffered frame in raster order, issuing one burst read per
// pulse, throttled by pixel-FIFO credits, a minimum issue gap and r_busy.
module frame_read_scheduler
    import frame_read_scheduler_pkg::*;
#(
    parameter int          BURSTS_PER_LINE = DEF_BURSTS_PER_LINE,
    parameter int          LINES           = DEF_LINES,
    parameter logic [31:0] ADDR_INC        = DEF_ADDR_INC,
    parameter logic [31:0] BASE_A          = DEF_BASE_A,
    parameter logic [31:0] BASE_B          = DEF_BASE_B,
    parameter int          FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int          GAP             = DEF_GAP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phy_init_done,
    input  logic        vsync_start,
    input  logic        burst_pop,
    input  logic        r_busy,
    input  logic        frame_ready,
    output logic        read_out,
    output logic [31:0] r_address_out,
    output logic        active_buf,
    output logic        frame_ack,
    output logic        fifo_flush,
    output logic        underrun
);

    localparam int BW = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] burstCnt_q, burstCnt_d;
    logic [LW-1:0] lineCnt_q, lineCnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   addr_q, addr_d;
    logic          swapPending_q, swapPending_d;
    logic          activeBuf_q, activeBuf_d;
    logic          underrun_q, underrun_d;
    logic          readOut_q, readOut_d;
    logic          frameAck_q, frameAck_d;
    logic          fifoFlush_q, fifoFlush_d;

    logic credLoad, credInc, credDec, credZero;
    logic frameStart, issue;

    credit_counter #(.DEPTH(FIFO_DEPTH)) uCredits (
        .clk    (clk),
        .reset  (reset),
        .load_i (credLoad),
        .inc_i  (credInc),
        .dec_i  (credDec),
        .zero_o (credZero)
    );

    assign frameStart = vsync_start && (state_q != ST_IDLE);
    assign issue      = (state_q == ST_FETCH) && !credZero && !r_busy &&
                        (gap_q == '0) && !vsync_start;

    // The gap counter keeps running across a frame restart so the minimum
    // spacing between read pulses also holds when vsync cuts a frame short.
    always_comb begin
        state_d       = state_q;
        burstCnt_d    = burstCnt_q;
        lineCnt_d     = lineCnt_q;
        gap_d         = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        acc_d         = acc_q;
        addr_d        = addr_q;
        swapPending_d = swapPending_q | frame_ready;
        activeBuf_d   = activeBuf_q;
        underrun_d    = underrun_q;
        readOut_d     = 1'b0;
        frameAck_d    = 1'b0;
        fifoFlush_d   = 1'b0;
        credLoad      = 1'b0;
        credInc       = burst_pop;
        credDec       = 1'b0;

        if (!phy_init_done) begin
            state_d    = ST_IDLE;
            burstCnt_d = '0;
            lineCnt_d  = '0;
            gap_d      = '0;
            acc_d      = '0;
            addr_d     = '0;
            credLoad   = 1'b1;
            credInc    = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_WAIT_VSYNC;
        end else if (frameStart) begin
            state_d     = ST_FETCH;
            burstCnt_d  = '0;
            lineCnt_d   = '0;
            fifoFlush_d = 1'b1;
            credLoad    = 1'b1;
            credInc     = 1'b0;
            if (state_q == ST_FETCH) underrun_d = 1'b1;
            if (swapPending_q || frame_ready) begin
                activeBuf_d   = ~activeBuf_q;
                frameAck_d    = 1'b1;
                swapPending_d = 1'b0;
                acc_d         = activeBuf_q ? BASE_A : BASE_B;
            end else begin
                acc_d         = activeBuf_q ? BASE_B : BASE_A;
            end
        end else if (issue) begin
            readOut_d = 1'b1;
            addr_d    = acc_q;
            acc_d     = acc_q + ADDR_INC;
            credDec   = 1'b1;
            gap_d     = GW'(GAP - 1);
            if (burstCnt_q == BW'(BURSTS_PER_LINE - 1)) begin
                burstCnt_d = '0;
                if (lineCnt_q == LW'(LINES - 1)) begin
                    lineCnt_d = '0;
                    state_d   = ST_FRAME_DONE;
                end else begin
                    lineCnt_d = lineCnt_q + LW'(1);
                end
            end else begin
                burstCnt_d = burstCnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            burstCnt_q    <= '0;
            lineCnt_q     <= '0;
            gap_q         <= '0;
            acc_q         <= '0;
            addr_q        <= '0;
            swapPending_q <= 1'b0;
            activeBuf_q   <= 1'b0;
            underrun_q    <= 1'b0;
            readOut_q     <= 1'b0;
            frameAck_q    <= 1'b0;
            fifoFlush_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            burstCnt_q    <= burstCnt_d;
            lineCnt_q     <= lineCnt_d;
            gap_q         <= gap_d;
            acc_q         <= acc_d;
            addr_q        <= addr_d;
            swapPending_q <= swapPending_d;
            activeBuf_q   <= activeBuf_d;
            underrun_q    <= underrun_d;
            readOut_q     <= readOut_d;
            frameAck_q    <= frameAck_d;
            fifoFlush_q   <= fifoFlush_d;
        end
    end

    assign read_out      = readOut_q;
    assign r_address_out = addr_q;
    assign active_buf    = activeBuf_q;
    assign frame_ack     = frameAck_q;
    assign fifo_flush    = fifoFlush_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_frame_read_scheduler.sv
// Bench for frame_read_scheduler on a reduced 4x2 frame: a frame-level model
// checked every cycle, plus literal expectations for key addresses and flags.
module tb_frame_read_scheduler;

    localparam int          BPL   = 4;
    localparam int          LN    = 2;
    localparam int          DEPTH = 3;
    localparam int          GAP   = 5;
    localparam logic [31:0] INC   = 32'd96;
    localparam logic [31:0] BA    = 32'h0000_0000;
    localparam logic [31:0] BB    = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        phy = 1'b0;
    logic        vsync = 1'b0;
    logic        pop = 1'b0;
    logic        busy = 1'b0;
    logic        ready = 1'b0;
    logic        read_out;
    logic [31:0] r_address_out;
    logic        active_buf;
    logic        frame_ack;
    logic        fifo_flush;
    logic        underrun;

    always #5 clk = ~clk;

    frame_read_scheduler #(
        .BURSTS_PER_LINE (BPL),
        .LINES           (LN),
        .ADDR_INC        (INC),
        .BASE_A          (BA),
        .BASE_B          (BB),
        .FIFO_DEPTH      (DEPTH),
        .GAP             (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .phy_init_done (phy),
        .vsync_start   (vsync),
        .burst_pop     (pop),
        .r_busy        (busy),
        .frame_ready   (ready),
        .read_out      (read_out),
        .r_address_out (r_address_out),
        .active_buf    (active_buf),
        .frame_ack     (frame_ack),
        .fifo_flush    (fifo_flush),
        .underrun      (underrun)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          compareEn = 1'b0;
    logic [31:0] pulseAddr[$];
    int          pulseCycle[$];
    int          ackCount = 0;
    int          flushCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: tracks how many bursts of the current frame have gone
    // out and derives each address as base + index * increment.
    typedef enum int {M_IDLE, M_WAIT, M_FETCH, M_DONE} mode_t;
    mode_t       mMode = M_IDLE;
    int          mCredits = DEPTH;
    int          mGap = 0;
    int          mIssued = 0;
    bit          mPending = 1'b0;
    bit          mPend = 1'b0;
    bit          mActive = 1'b0;
    bit          mUnderrun = 1'b0;
    logic        eRead = 1'b0;
    logic        eAck = 1'b0;
    logic        eFlush = 1'b0;
    logic [31:0] eAddr = 32'h0;

    always @(posedge clk) begin
        cyc++;
        eRead  = 1'b0;
        eAck   = 1'b0;
        eFlush = 1'b0;
        if (reset) begin
            mMode = M_IDLE; mCredits = DEPTH; mGap = 0; mIssued = 0;
            mPending = 1'b0; mActive = 1'b0; mUnderrun = 1'b0; eAddr = 32'h0;
        end else if (!phy) begin
            mMode = M_IDLE; mCredits = DEPTH; mGap = 0; mIssued = 0;
            mPending = mPending | ready; eAddr = 32'h0;
        end else if (mMode == M_IDLE) begin
            mMode = M_WAIT;
            mPending = mPending | ready;
        end else begin
            mPend = mPending | ready;
            if (vsync) begin
                if (mMode == M_FETCH) mUnderrun = 1'b1;
                if (mPend) begin
                    mActive = !mActive;
                    eAck = 1'b1;
                    mPend = 1'b0;
                end
                eFlush = 1'b1;
                mCredits = DEPTH;
                mIssued = 0;
                mMode = M_FETCH;
                if (mGap > 0) mGap--;
            end else if (mMode == M_FETCH && mCredits > 0 && !busy && mGap == 0) begin
                eRead = 1'b1;
                eAddr = (mActive ? BB : BA) + INC * 32'(mIssued);
                mIssued++;
                if (!pop) mCredits--;
                mGap = GAP - 1;
                if (mIssued == BPL * LN) mMode = M_DONE;
            end else begin
                if (mGap > 0) mGap--;
                if (pop && mCredits < DEPTH) mCredits++;
            end
            mPending = mPend;
        end
    end

    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("read_out", {31'h0, read_out}, {31'h0, eRead});
            checkOutput("r_address_out", r_address_out, eAddr);
            checkOutput("active_buf", {31'h0, active_buf}, {31'h0, mActive});
            checkOutput("frame_ack", {31'h0, frame_ack}, {31'h0, eAck});
            checkOutput("fifo_flush", {31'h0, fifo_flush}, {31'h0, eFlush});
            checkOutput("underrun", {31'h0, underrun}, {31'h0, mUnderrun});
        end
        if (read_out === 1'b1) begin
            pulseAddr.push_back(r_address_out);
            pulseCycle.push_back(cyc);
        end
        if (frame_ack === 1'b1) ackCount++;
        if (fifo_flush === 1'b1) flushCount++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic vs, input logic rdy);
        vsync = vs;
        ready = rdy;
        step();
        vsync = 1'b0;
        ready = 1'b0;
    endtask

    task automatic runCycles(input int n, input int popPeriod);
        for (int i = 0; i < n; i++) begin
            pop = (popPeriod > 0) && (i % popPeriod == 0);
            step();
        end
        pop = 1'b0;
    endtask

    task automatic runUntil(input int target, input int maxCycles, input int popPeriod);
        int i;
        i = 0;
        while (pulseAddr.size() < target && i < maxCycles) begin
            pop = (popPeriod > 0) && (i % popPeriod == 0);
            step();
            i++;
        end
        pop = 1'b0;
        checkOutput($sformatf("reach_%0d_pulses", target), 32'(pulseAddr.size()), 32'(target));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        step(); step(); step();
        compareEn = 1'b1;
        checkOutput("reset_read_out", {31'h0, read_out}, 32'h0);
        checkOutput("reset_addr", r_address_out, 32'h0);
        checkOutput("reset_active_buf", {31'h0, active_buf}, 32'h0);
        checkOutput("reset_underrun", {31'h0, underrun}, 32'h0);
        checkOutput("reset_flush", {31'h0, fifo_flush}, 32'h0);
        reset = 1'b0;
        phy = 1'b1;
        runCycles(3, 0);

        $display("[TB] init and credit throttle");
        applyStimulus(1'b1, 1'b0);
        runCycles(40, 0);
        checkOutput("throttle_count", 32'(pulseAddr.size()), 32'd3);
        if (pulseAddr.size() >= 3) begin
            checkOutput("addr0", pulseAddr[0], 32'd0);
            checkOutput("addr1", pulseAddr[1], 32'd96);
            checkOutput("addr2", pulseAddr[2], 32'd192);
            checkOutput("gap01_ge5", {31'h0, (pulseCycle[1] - pulseCycle[0]) >= GAP}, 32'h1);
            checkOutput("gap12_ge5", {31'h0, (pulseCycle[2] - pulseCycle[1]) >= GAP}, 32'h1);
        end

        $display("[TB] credit return to end of frame");
        runUntil(8, 200, 10);
        if (pulseAddr.size() >= 8) checkOutput("last_addr", pulseAddr[7], 32'd672);
        runCycles(30, 10);
        checkOutput("frame_done_stall", 32'(pulseAddr.size()), 32'd8);
        checkOutput("no_underrun", {31'h0, underrun}, 32'h0);

        $display("[TB] r_busy hold");
        applyStimulus(1'b1, 1'b0);
        runUntil(10, 100, 0);
        busy = 1'b1;
        start = pulseAddr.size();
        runCycles(20, 0);
        checkOutput("busy_no_issue", 32'(pulseAddr.size()), 32'(start));
        busy = 1'b0;
        runCycles(2, 0);
        checkOutput("busy_release_issue", 32'(pulseAddr.size()), 32'(start + 1));
        if (pulseAddr.size() >= 11) checkOutput("busy_release_addr", pulseAddr[10], 32'd192);

        $display("[TB] buffer swap");
        runUntil(16, 300, 10);
        applyStimulus(1'b0, 1'b1);
        runCycles(3, 0);
        applyStimulus(1'b1, 1'b0);
        step();
        checkOutput("swap_ack_count", 32'(ackCount), 32'd1);
        checkOutput("swap_flush_count", 32'(flushCount), 32'd3);
        checkOutput("swap_active_buf", {31'h0, active_buf}, 32'h1);
        checkOutput("swap_no_underrun", {31'h0, underrun}, 32'h0);
        runUntil(17, 50, 0);
        if (pulseAddr.size() >= 17) checkOutput("swap_first_addr", pulseAddr[16], 32'h0010_0000);

        $display("[TB] underrun");
        runUntil(21, 200, 10);
        applyStimulus(1'b1, 1'b0);
        step();
        checkOutput("underrun_set", {31'h0, underrun}, 32'h1);
        checkOutput("underrun_flush_count", 32'(flushCount), 32'd4);
        runCycles(40, 0);
        checkOutput("underrun_reload_count", 32'(pulseAddr.size()), 32'd24);
        if (pulseAddr.size() >= 24) begin
            checkOutput("restart_addr0", pulseAddr[21], 32'h0010_0000);
            checkOutput("restart_addr1", pulseAddr[22], 32'h0010_0060);
            checkOutput("restart_addr2", pulseAddr[23], 32'h0010_00C0);
        end
        checkOutput("underrun_sticky", {31'h0, underrun}, 32'h1);

        $display("[TB] reset mid-fetch");
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst2_read_out", {31'h0, read_out}, 32'h0);
        checkOutput("rst2_addr", r_address_out, 32'h0);
        checkOutput("rst2_active_buf", {31'h0, active_buf}, 32'h0);
        checkOutput("rst2_underrun", {31'h0, underrun}, 32'h0);
        runCycles(20, 0);
        checkOutput("rst2_no_issue", 32'(pulseAddr.size()), 32'd24);
        applyStimulus(1'b1, 1'b0);
        runUntil(25, 50, 0);
        if (pulseAddr.size() >= 25) checkOutput("rst2_first_addr", pulseAddr[24], 32'h0);
        runCycles(3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
